// File: rtl/circulant_transpose_ctrl.sv
// rtl/circulant_transpose_ctrl.sv - row-major fill / column-major drain sequencer for a circulant word-sliced store
// Optional statistics ports are enabled with CIRC_XPOSE_STATS_EN.
module circulant_transpose_ctrl #(
    parameter int MATRIX_DIM = 4,
    parameter int COL_WIDTH  = 8,
    parameter int WORD_LEN   = 32,
    parameter int ADDR_LEN   = $clog2(MATRIX_DIM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WORD_LEN-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [WORD_LEN-1:0] m_data,
    output logic                m_last,
    output logic                mem_write_en,
    output logic [ADDR_LEN-1:0] mem_write_row,
    output logic [ADDR_LEN-1:0] mem_write_col,
    output logic [WORD_LEN-1:0] mem_data_in,
    output logic                mem_read_en,
    output logic [ADDR_LEN-1:0] mem_read_row,
    output logic [ADDR_LEN-1:0] mem_read_col,
    input  logic [WORD_LEN-1:0] mem_data_out,
    output logic                busy
`ifdef CIRC_XPOSE_STATS_EN
    ,
    output logic [15:0]         frame_count,
    output logic [15:0]         stall_count
`endif
);

    localparam int CPW    = WORD_LEN / COL_WIDTH;
    localparam int WPR    = MATRIX_DIM / CPW;
    localparam int NWORDS = MATRIX_DIM * WPR;
    localparam int CNT_W  = $clog2(NWORDS) + 1;
    localparam logic [CNT_W-1:0] CPW_C   = CNT_W'(CPW);
    localparam logic [CNT_W-1:0] WPR_M1  = CNT_W'(WPR - 1);
    localparam logic [CNT_W-1:0] DIM_M1  = CNT_W'(MATRIX_DIM - 1);
    localparam logic [CNT_W-1:0] LAST_IX = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {ST_FILL, ST_DRAIN, ST_FLUSH} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d, wcol_q, wcol_d, wrow_q, wrow_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d, rk_q, rk_d, rc_q, rc_d;
    logic               pend_q, pend_last_q, pend_last_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [WORD_LEN-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic               last0_q, last0_d, last1_q, last1_d;
    logic               pop, can_issue;

    assign m_valid       = (cnt_q != 2'd0);
    assign m_data        = buf0_q;
    assign m_last        = m_valid && last0_q;
    assign pop           = m_valid && m_ready;
    assign mem_data_in   = s_data;
    assign mem_write_row = ADDR_LEN'(wrow_q);
    assign mem_write_col = ADDR_LEN'(wcol_q * CPW_C);
    assign mem_read_row  = ADDR_LEN'(rk_q * CPW_C);
    assign mem_read_col  = ADDR_LEN'(rc_q);
    assign busy          = (state_q != ST_FILL) || (wr_cnt_q != '0);

    // A read may issue only if the word it returns is guaranteed a buffer slot,
    // counting the slot freed by a handshake in this same cycle.
    assign can_issue = (cnt_q == 2'd0) ||
                       (cnt_q == 2'd1 && (!pend_q || pop)) ||
                       (cnt_q == 2'd2 && !pend_q && pop);

    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        wcol_d       = wcol_q;
        wrow_d       = wrow_q;
        rd_cnt_d     = rd_cnt_q;
        rk_d         = rk_q;
        rc_d         = rc_q;
        pend_last_d  = 1'b0;
        s_ready      = 1'b0;
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        case (state_q)
            ST_FILL: begin
                s_ready      = 1'b1;
                mem_write_en = s_valid;
                if (s_valid) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wcol_q == WPR_M1) begin
                        wcol_d = '0;
                        wrow_d = wrow_q + 1'b1;
                    end else begin
                        wcol_d = wcol_q + 1'b1;
                    end
                    if (wr_cnt_q == LAST_IX) begin
                        state_d  = ST_DRAIN;
                        wr_cnt_d = '0;
                        wcol_d   = '0;
                        wrow_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (can_issue) begin
                    mem_read_en = 1'b1;
                    rd_cnt_d    = rd_cnt_q + 1'b1;
                    if (rk_q == WPR_M1) begin
                        rk_d = '0;
                        rc_d = (rc_q == DIM_M1) ? '0 : rc_q + 1'b1;
                    end else begin
                        rk_d = rk_q + 1'b1;
                    end
                    if (rd_cnt_q == LAST_IX) begin
                        pend_last_d = 1'b1;
                        state_d     = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (pop && last0_q) begin
                    state_d  = ST_FILL;
                    rd_cnt_d = '0;
                    rk_d     = '0;
                    rc_d     = '0;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Two-entry skid buffer; store data lands one cycle after its read strobe.
    always_comb begin
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        cnt_d   = cnt_q;
        if (pend_q && pop) begin
            if (cnt_q == 2'd1) begin
                buf0_d  = mem_data_out;
                last0_d = pend_last_q;
            end else begin
                buf0_d  = buf1_q;
                last0_d = last1_q;
                buf1_d  = mem_data_out;
                last1_d = pend_last_q;
            end
        end else if (pend_q) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd0) begin
                buf0_d  = mem_data_out;
                last0_d = pend_last_q;
            end else begin
                buf1_d  = mem_data_out;
                last1_d = pend_last_q;
            end
        end else if (pop) begin
            cnt_d   = cnt_q - 2'd1;
            buf0_d  = buf1_q;
            last0_d = last1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            wr_cnt_q    <= '0;
            wcol_q      <= '0;
            wrow_q      <= '0;
            rd_cnt_q    <= '0;
            rk_q        <= '0;
            rc_q        <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            cnt_q       <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            wcol_q      <= wcol_d;
            wrow_q      <= wrow_d;
            rd_cnt_q    <= rd_cnt_d;
            rk_q        <= rk_d;
            rc_q        <= rc_d;
            pend_q      <= mem_read_en;
            pend_last_q <= pend_last_d;
            cnt_q       <= cnt_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
        end
    end

`ifdef CIRC_XPOSE_STATS_EN
    logic [15:0] frame_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= 16'h0000;
            stall_q <= 16'h0000;
        end else begin
            if (pop && last0_q) begin
                frame_q <= frame_q + 16'h0001;
            end
            if (m_valid && !m_ready && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'h0001;
            end
        end
    end

    assign frame_count = frame_q;
    assign stall_count = stall_q;
`endif

endmodule
